// File: rtl/dl_updi_pkg.sv
// dl_updi_pkg: UPDI data-link opcodes, characters and FSM states
// shared by the DL command decoder and the host-side encoder.
package dl_updi_pkg;

  typedef enum logic [2:0] {
    LDS  = 3'b000,
    LD   = 3'b001,
    STS  = 3'b010,
    ST   = 3'b011,
    LDCS = 3'b100,
    REP  = 3'b101,
    STCS = 3'b110,
    KEY  = 3'b111
  } comands;

  localparam logic [7:0] SYNCH_CHAR = 8'h55;
  localparam logic [7:0] ACK_CHAR   = 8'h40;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_SYNC,
    S_TX_OP,
    S_TX_ADR0,
    S_TX_ADR1,
    S_TX_DAT0,
    S_TX_DAT1,
    S_RX_ACK,
    S_RX_DAT0,
    S_RX_DAT1,
    S_RESP
  } dl_state_e;

  // Opcode byte for the four ops the encoder can frame.
  function automatic logic [7:0] build_opcode(
    input comands     op,
    input logic       word,
    input logic [3:0] cs
  );
    logic [7:0] b;
    case (op)
      LDS:     b = 8'h04 | {7'd0, word};
      STS:     b = 8'h44 | {7'd0, word};
      LDCS:    b = 8'h80 | {4'd0, cs};
      STCS:    b = 8'hC0 | {4'd0, cs};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic op_supported(input comands op);
    return (op == LDS) || (op == STS) ||
           (op == LDCS) || (op == STCS);
  endfunction

endpackage

// File: rtl/dl_rx_timeout.sv
// dl_rx_timeout: per-byte receive watchdog.
// Cleared on entry to a wait state, counts idle cycles, flags expiry.
module dl_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LAST);

  // Saturating count of cycles spent waiting without a byte.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dl_cmd_encoder.sv
// dl_cmd_encoder: host-side UPDI data-link framer.
// Serialises LDS/STS/LDCS/STCS frames and collects data or ACKs.
module dl_cmd_encoder
  import dl_updi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  SYNCH_BYTE  = SYNCH_CHAR,
  parameter logic [7:0]  ACK_BYTE    = ACK_CHAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_cs,
  input  logic [15:0] req_addr,
  input  logic        req_word,
  input  logic [15:0] req_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  dl_state_e state_q, state_d;

  comands      op_q;
  logic        word_q;
  logic [3:0]  cs_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;

  logic        err_q, err_d;
  logic        ack2_q, ack2_d;
  logic [15:0] rdata_q, rdata_d;

  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [15:0] rsp_rdata_q;
  logic        busy_q;

  logic accept;
  logic tx_hs;
  logic in_rx;
  logic expired;
  comands req_op_e;

  assign req_op_e  = comands'(req_op);
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign tx_hs     = tx_valid_q && tx_ready;
  assign in_rx     = state_q inside {S_RX_ACK, S_RX_DAT0, S_RX_DAT1};

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;

  dl_rx_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (state_d != state_q),
    .en_i     (in_rx && !rx_valid),
    .expired_o(expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing, ACK checking and load-data capture.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ack2_d  = ack2_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          err_d   = 1'b0;
          ack2_d  = 1'b0;
          rdata_d = '0;
          if (op_supported(req_op_e)) begin
            state_d = S_TX_SYNC;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_TX_SYNC: begin
        if (tx_hs) state_d = S_TX_OP;
      end
      S_TX_OP: begin
        if (tx_hs) begin
          if (op_q == LDCS) begin
            state_d = S_RX_DAT0;
          end else if (op_q == STCS) begin
            state_d = S_TX_DAT0;
          end else begin
            state_d = S_TX_ADR0;
          end
        end
      end
      S_TX_ADR0: begin
        if (tx_hs) state_d = S_TX_ADR1;
      end
      S_TX_ADR1: begin
        if (tx_hs) begin
          state_d = (op_q == STS) ? S_RX_ACK : S_RX_DAT0;
        end
      end
      S_TX_DAT0: begin
        if (tx_hs) begin
          if (op_q == STCS) begin
            state_d = S_RESP;
          end else if (word_q) begin
            state_d = S_TX_DAT1;
          end else begin
            state_d = S_RX_ACK;
          end
        end
      end
      S_TX_DAT1: begin
        if (tx_hs) state_d = S_RX_ACK;
      end
      S_RX_ACK: begin
        if (rx_valid) begin
          if (rx_data != ACK_BYTE) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (ack2_q) begin
            state_d = S_RESP;
          end else begin
            ack2_d  = 1'b1;
            state_d = S_TX_DAT0;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RX_DAT0: begin
        if (rx_valid) begin
          rdata_d[7:0] = rx_data;
          if (op_q == LDS && word_q) begin
            state_d = S_RX_DAT1;
          end else begin
            state_d = S_RESP;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RX_DAT1: begin
        if (rx_valid) begin
          rdata_d[15:8] = rx_data;
          state_d       = S_RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte presented to the PHY for the state being entered.
  always_comb begin
    tx_valid_d = 1'b1;
    tx_data_d  = 8'h00;
    unique case (state_d)
      S_TX_SYNC: tx_data_d = SYNCH_BYTE;
      S_TX_OP:   tx_data_d = build_opcode(op_q, word_q, cs_q);
      S_TX_ADR0: tx_data_d = addr_q[7:0];
      S_TX_ADR1: tx_data_d = addr_q[15:8];
      S_TX_DAT0: tx_data_d = wdata_q[7:0];
      S_TX_DAT1: tx_data_d = wdata_q[15:8];
      default:   tx_valid_d = 1'b0;
    endcase
  end

  // Request latch and transaction bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= LDS;
      word_q  <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ack2_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op_e;
        word_q  <= req_word &&
                   (req_op_e == LDS || req_op_e == STS);
        cs_q    <= req_cs;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      err_q   <= err_d;
      ack2_q  <= ack2_d;
      rdata_q <= rdata_d;
    end
  end

  // Registered PHY and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      if (state_d == S_RESP) begin
        rsp_err_q   <= err_d;
        rsp_rdata_q <= rdata_d;
      end
    end
  end

endmodule
